seq_deser_detect: RTL and testbench

Downstream consumer of the serial single-bit output of the sequential state-machine stage. It samples that bit stream under a qualifier and assembles MSB-first WIDTH-bit words, which it offers on a valid/ready output register. In parallel it runs an overlapping PATTERN detector that produces a match pulse and a saturating match count. Words that arrive while the output register is still occupied are dropped and flagged.

---
 rtl/seq_deser_detect_if.sv | 25 ++
 rtl/seq_deser_detect.sv | 114 +++++++++++
 tb/tb_seq_deser_detect.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_deser_detect_if.sv
// Bus bundle for seq_deser_detect: serial bit input plus the word and match outputs.
// The master side is the deserializer; the slave side is whoever feeds and drains it.
interface seq_deser_detect_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             ovf;

  modport master (
    input  din, din_vld, out_rdy,
    output dout, dout_vld, match, match_cnt, ovf
  );

  modport slave (
    output din, din_vld, out_rdy,
    input  dout, dout_vld, match, match_cnt, ovf
  );
endinterface

// File: rtl/seq_deser_detect.sv
// Serial-to-parallel MSB-first word assembler with a one-deep output register,
// plus an overlapping pattern detector with a saturating match counter.
module seq_deser_detect #(
  parameter int                   WIDTH   = 8,
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter int                   CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_deser_detect_if.master   bus
);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FCW = $clog2(PAT_LEN + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [FCW-1:0] FILL_FULL = FCW'(PAT_LEN);
  localparam logic [FCW-1:0] FILL_MIN  = FCW'(PAT_LEN - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-2:0]   sh_q, sh_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               ovf_q, ovf_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FCW-1:0]     fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

  logic               acc;
  logic               complete;
  logic [WIDTH-1:0]   word;
  logic [PAT_LEN-1:0] hist_nx;

  // Datapath: shift register, bit counter and pattern history.
  always_comb begin
    acc       = bus.din_vld;
    word      = {sh_q, bus.din};
    complete  = acc && (bit_cnt_q == BIT_LAST);
    hist_nx   = PAT_LEN'({hist_q, bus.din});

    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (acc) begin
      sh_d      = word[WIDTH-2:0];
      bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
      hist_d    = hist_nx;
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
    end

    // fill_q >= PAT_LEN-1 means the current bit brings the history to full depth.
    match_d     = acc && (hist_nx == PATTERN) && (fill_q >= FILL_MIN);
    match_cnt_d = match_cnt_q;
    if (match_d && (match_cnt_q != '1)) match_cnt_d = match_cnt_q + 1'b1;
  end

  // Output register FSM; dout_vld is the FULL state itself, so it never
  // depends combinationally on out_rdy.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          dout_d  = word;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.out_rdy) begin
          if (complete) dout_d = word;
          else          state_d = EMPTY;
        end else if (complete) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = (state_q == FULL);
  assign bus.match     = match_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_deser_detect.sv
// Directed bench for seq_deser_detect: a default instance plus a CNT_W=2 twin
// fed the same stimulus to exercise counter saturation.
module tb_seq_deser_detect;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pulses;

  seq_deser_detect_if #(.WIDTH(8), .CNT_W(8)) m_if ();
  seq_deser_detect_if #(.WIDTH(8), .CNT_W(2)) s_if ();

  assign s_if.din     = m_if.din;
  assign s_if.din_vld = m_if.din_vld;
  assign s_if.out_rdy = m_if.out_rdy;

  seq_deser_detect #(.WIDTH(8), .PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if)
  );
  seq_deser_detect #(.WIDTH(8), .PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic b, input logic v);
    m_if.din     = b;
    m_if.din_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    m_if.din_vld = 1'b0;
    m_if.din     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1);
  endtask

  initial begin
    logic [7:0]  w;
    logic [27:0] pat7;

    // Reset with toggling inputs
    rst_n = 1'b0;
    m_if.out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_if.out_rdy = i[0];
      step(i[1], 1'b1);
    end
    chk("rst_dout",     m_if.dout, 0);
    chk("rst_dout_vld", m_if.dout_vld, 0);
    chk("rst_match",    m_if.match, 0);
    chk("rst_cnt",      m_if.match_cnt, 0);
    chk("rst_ovf",      m_if.ovf, 0);

    // Basic word 1,0,1,1,0,0,1,0 with match at bit 4
    do_reset();
    m_if.out_rdy = 1'b1;
    w = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], 1'b1);
      chk($sformatf("basic_match_%0d", i), m_if.match, (i == 3) ? 1 : 0);
      if (i < 7) chk($sformatf("basic_vld_%0d", i), m_if.dout_vld, 0);
    end
    chk("basic_cnt",  m_if.match_cnt, 1);
    chk("basic_dout", m_if.dout, 8'hB2);
    chk("basic_vld",  m_if.dout_vld, 1);
    step(1'b0, 1'b0);
    chk("basic_drain_vld",  m_if.dout_vld, 0);
    chk("basic_drain_dout", m_if.dout, 8'hB2);

    // Overlap with two idle cycles between bits
    do_reset();
    w = 8'b1011_0110;
    for (int i = 0; i < 7; i++) begin
      step(w[7-i], 1'b1);
      chk($sformatf("ovl_match_%0d", i), m_if.match, (i == 3 || i == 6) ? 1 : 0);
      for (int g = 0; g < 2; g++) begin
        step(1'b1, 1'b0);
        chk($sformatf("ovl_gap_match_%0d_%0d", i, g), m_if.match, 0);
      end
    end
    chk("ovl_cnt", m_if.match_cnt, 2);
    chk("ovl_vld", m_if.dout_vld, 0);

    // Backpressure and overflow
    do_reset();
    m_if.out_rdy = 1'b0;
    send_word(8'hA5);
    chk("bp_dout1", m_if.dout, 8'hA5);
    chk("bp_vld1",  m_if.dout_vld, 1);
    chk("bp_ovf1",  m_if.ovf, 0);
    send_word(8'h3C);
    chk("bp_dout2", m_if.dout, 8'hA5);
    chk("bp_vld2",  m_if.dout_vld, 1);
    chk("bp_ovf2",  m_if.ovf, 1);
    m_if.out_rdy = 1'b1;
    step(1'b0, 1'b0);
    chk("bp_drain_vld", m_if.dout_vld, 0);
    chk("bp_drain_ovf", m_if.ovf, 1);
    chk("bp_drain_dout", m_if.dout, 8'hA5);

    // Drain and complete on the same edge
    do_reset();
    m_if.out_rdy = 1'b0;
    send_word(8'h11);
    chk("sim_dout1", m_if.dout, 8'h11);
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) m_if.out_rdy = 1'b1;
      step(w[7-i], 1'b1);
    end
    chk("sim_dout2", m_if.dout, 8'h5A);
    chk("sim_vld2",  m_if.dout_vld, 1);
    chk("sim_ovf",   m_if.ovf, 0);

    // Async reset mid-pattern while a word is held
    m_if.out_rdy = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("mid_pre_vld", m_if.dout_vld, 1);
    m_if.din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_vld",  m_if.dout_vld, 0);
    chk("mid_async_dout", m_if.dout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_if.out_rdy = 1'b1;
    w = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], 1'b1);
      chk($sformatf("mid_match_%0d", i), m_if.match, 0);
    end
    chk("mid_dout", m_if.dout, 8'hC0);
    chk("mid_vld",  m_if.dout_vld, 1);
    chk("mid_cnt",  m_if.match_cnt, 0);

    // Saturation of a 2-bit counter over seven patterns
    do_reset();
    pat7   = {7{4'b1011}};
    pulses = 0;
    for (int i = 27; i >= 0; i--) begin
      step(pat7[i], 1'b1);
      if (s_if.match === 1'b1) pulses++;
      if (i == 16) chk("sat_cnt_at3", s_if.match_cnt, 3);
    end
    chk("sat_pulses",   pulses, 7);
    chk("sat_cnt",      s_if.match_cnt, 3);
    chk("sat_wide_cnt", m_if.match_cnt, 7);
    step(1'b0, 1'b0);
    chk("sat_match_low", s_if.match, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
